// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges MiST joystick and keyboard inputs into active-low cabinet signals with rotation, SOCD and coin pulses.
// Optional ARCADE_INPUT_AUTOFIRE_EN adds the autofire input and AUTOFIRE_DIV parameter.
module arcade_input_mapper #(
    parameter int          PLAYERS         = 2,
    parameter logic [15:0] COIN_PULSE      = 16'd50000,
    parameter logic [15:0] COIN_GAP        = 16'd50000,
    parameter bit          SOCD_EN_DEFAULT = 1'b1
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    parameter logic [15:0] AUTOFIRE_DIV    = 16'd25000
`endif
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [7:0]         joystick_0,
    input  logic [7:0]         joystick_1,
    input  logic [9:0]         kbjoy,
    input  logic [1:0]         rotate,
    input  logic               share,
    input  logic               socd_en,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic               autofire,
`endif
    output logic [PLAYERS-1:0] up_n,
    output logic [PLAYERS-1:0] down_n,
    output logic [PLAYERS-1:0] left_n,
    output logic [PLAYERS-1:0] right_n,
    output logic [PLAYERS-1:0] fire_n,
    output logic [PLAYERS-1:0] bomb_n,
    output logic [PLAYERS-1:0] start_n,
    output logic [PLAYERS-1:0] coin_n
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
    logic               socd_q;
    logic               unused_kb;
    logic [3:0]         all_dir;
    logic               all_fire, all_bomb;
    logic [PLAYERS-1:0] up_nx, down_nx, left_nx, right_nx, fire_nx, bomb_nx, start_nx, coin_nx;
    assign unused_kb = kbjoy[9];
    // Direction nibbles are {U, D, L, R}, matching joystick bits [3:0]
    assign all_dir  = joystick_0[3:0] | joystick_1[3:0] | {kbjoy[4], kbjoy[5], kbjoy[6], kbjoy[7]};
    assign all_fire = joystick_0[4] | joystick_1[4] | kbjoy[0];
    assign all_bomb = joystick_0[5] | joystick_1[5] | kbjoy[8];
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [7:0]  joy;
        logic        kb_en;
        logic [3:0]  dir, rot, clean;
        logic        m_fire, m_bomb, req, prev;
        coin_state_t state, state_nx;
        logic [15:0] cnt, cnt_nx;
        assign joy    = (p == 0) ? joystick_0 : joystick_1;
        assign kb_en  = (p == 0);
        assign dir    = share ? all_dir : joy[3:0] | ({kbjoy[4], kbjoy[5], kbjoy[6], kbjoy[7]} & {4{kb_en}});
        assign m_fire = share ? all_fire : joy[4] | (kbjoy[0] & kb_en);
        assign m_bomb = share ? all_bomb : joy[5] | (kbjoy[8] & kb_en);
        assign req    = joy[7] | (kbjoy[3] & kb_en);
        always_comb begin
            rot = dir;
            case (rotate)
                2'd1:    rot = {dir[0], dir[1], dir[3], dir[2]};
                2'd2:    rot = {dir[1], dir[0], dir[2], dir[3]};
                2'd3:    rot = {dir[2], dir[3], dir[0], dir[1]};
                default: rot = dir;
            endcase
            clean[3:2] = (socd_q && rot[3] && rot[2]) ? 2'b00 : rot[3:2];
            clean[1:0] = (socd_q && rot[1] && rot[0]) ? 2'b00 : rot[1:0];
        end
        assign up_nx[p]    = ~clean[3];
        assign down_nx[p]  = ~clean[2];
        assign left_nx[p]  = ~clean[1];
        assign right_nx[p] = ~clean[0];
        assign bomb_nx[p]  = ~m_bomb;
        assign start_nx[p] = ~(joy[6] | kbjoy[1 + p]);
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt + 16'd1;
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (req && !prev) state_nx = PULSE;
                end
                PULSE: if (cnt == COIN_PULSE - 16'd1) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end
                GAP: if (cnt == COIN_GAP - 16'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
        // prev loads 1 in reset so a coin key held through reset is not an edge
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                prev  <= 1'b1;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                prev  <= req;
            end
        end
        assign coin_nx[p] = (state_nx != PULSE);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        logic        held, lvl, lvl_nx;
        logic [15:0] af_cnt, af_cnt_nx;
        always_comb begin
            lvl_nx    = lvl;
            af_cnt_nx = '0;
            if (m_fire && !held) lvl_nx = 1'b1;
            else if (m_fire) begin
                af_cnt_nx = (af_cnt == AUTOFIRE_DIV - 16'd1) ? 16'd0 : af_cnt + 16'd1;
                lvl_nx    = (af_cnt == AUTOFIRE_DIV - 16'd1) ? ~lvl : lvl;
            end
        end
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                held   <= 1'b0;
                lvl    <= 1'b0;
                af_cnt <= '0;
            end else begin
                held   <= m_fire;
                lvl    <= lvl_nx;
                af_cnt <= af_cnt_nx;
            end
        end
        assign fire_nx[p] = ~(m_fire & (~autofire | lvl_nx));
`else
        assign fire_nx[p] = ~m_fire;
`endif
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            socd_q  <= SOCD_EN_DEFAULT;
            up_n    <= '1;
            down_n  <= '1;
            left_n  <= '1;
            right_n <= '1;
            fire_n  <= '1;
            bomb_n  <= '1;
            start_n <= '1;
            coin_n  <= '1;
        end else begin
            socd_q  <= socd_en;
            up_n    <= up_nx;
            down_n  <= down_nx;
            left_n  <= left_nx;
            right_n <= right_nx;
            fire_n  <= fire_nx;
            bomb_n  <= bomb_nx;
            start_n <= start_nx;
            coin_n  <= coin_nx;
        end
    end
endmodule
